div_iter_unit: RTL and testbench

//   Multi-cycle restoring divider; the responder side of the EX-stage divide handshake.
//   EX holds start_i with operands while ready_o=0, and drops start_i once it sees ready_o=1.

---
 rtl/div_iter_unit.sv | 149 ++++++++++++++
 tb/tb_div_iter_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - multi-cycle restoring divider for DIV/DIVU in EX
// Returns {remainder, quotient}; one quotient bit per cycle on sign-stripped operands.
module div_iter_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [2*DATA_W:0]   shreg, shreg_nxt;
   logic [DATA_W-1:0]   divisor, divisor_nxt;
   logic                q_neg, q_neg_nxt;
   logic                r_neg, r_neg_nxt;
   logic [2*DATA_W-1:0] result_nxt;
   logic                ready_nxt;

   logic                s1, s2;
   logic [DATA_W-1:0]   abs1, abs2;
   logic [2*DATA_W:0]   shifted;
   logic [DATA_W+1:0]   diff;
   logic                quo_bit;
   logic [2*DATA_W:0]   step;
   logic [DATA_W-1:0]   quo_mag, rem_mag, quo_fix, rem_fix;

   // Operand magnitudes; only signed ops with a set MSB are negated.
   always_comb begin
      s1   = signed_div_i & opdata1_i[DATA_W-1];
      s2   = signed_div_i & opdata2_i[DATA_W-1];
      abs1 = s1 ? -opdata1_i : opdata1_i;
      abs2 = s2 ? -opdata2_i : opdata2_i;
   end

   // One restoring step: shift left, trial-subtract from the upper DATA_W+1 bits.
   // The extra diff bit is the borrow that says the trial went negative.
   always_comb begin
      shifted = shreg << 1;
      diff    = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, divisor};
      quo_bit = ~diff[DATA_W+1];
      step[2*DATA_W:DATA_W] = quo_bit ? diff[DATA_W:0] : shifted[2*DATA_W:DATA_W];
      step[DATA_W-1:0]      = shifted[DATA_W-1:0] | {{(DATA_W-1){1'b0}}, quo_bit};
      quo_mag = step[DATA_W-1:0];
      rem_mag = step[2*DATA_W-1:DATA_W];
      quo_fix = q_neg ? -quo_mag : quo_mag;
      rem_fix = r_neg ? -rem_mag : rem_mag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         divisor  <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         shreg    <= shreg_nxt;
         divisor  <= divisor_nxt;
         q_neg    <= q_neg_nxt;
         r_neg    <= r_neg_nxt;
         result_o <= result_nxt;
         ready_o  <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      shreg_nxt   = shreg;
      divisor_nxt = divisor;
      q_neg_nxt   = q_neg;
      r_neg_nxt   = r_neg;
      result_nxt  = result_o;
      ready_nxt   = ready_o;

      case (state)
         IDLE: begin
            result_nxt = '0;
            ready_nxt  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  // Divide-by-zero answers immediately with an all-zero result.
                  state_nxt = DONE;
                  ready_nxt = 1'b1;
               end else begin
                  state_nxt   = BUSY;
                  cnt_nxt     = '0;
                  shreg_nxt   = {{(DATA_W+1){1'b0}}, abs1};
                  divisor_nxt = abs2;
                  q_neg_nxt   = s1 ^ s2;
                  r_neg_nxt   = s1;
               end
            end
         end

         BUSY: begin
            if (annul_i || !start_i) begin
               state_nxt  = IDLE;
               result_nxt = '0;
               ready_nxt  = 1'b0;
            end else begin
               shreg_nxt = step;
               cnt_nxt   = cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  state_nxt  = DONE;
                  result_nxt = {rem_fix, quo_fix};
                  ready_nxt  = 1'b1;
               end
            end
         end

         DONE: begin
            if (!start_i || annul_i) begin
               state_nxt  = IDLE;
               result_nxt = '0;
               ready_nxt  = 1'b0;
            end
         end

         default: begin
            state_nxt  = IDLE;
            result_nxt = '0;
            ready_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - directed and randomized checks of div_iter_unit
// Expected results come from plain integer division with the MIPS DIV/DIVU rules.
module tb_div_iter_unit;

   localparam int DATA_W = 32;
   localparam int N_RAND = 1200;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_iter_unit #(.DATA_W(32), .CNT_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return 64'd0;
      if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
      end
      return {r, q};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one divide, wait for ready_o, optionally hold in DONE, then release.
   task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int extra, input bit scramble, input bit by_annul);
      int edges;
      int lat;
      edges = 0;
      lat = (b == 32'd0) ? 1 : DATA_W + 1;
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      annul_i      = 1'b0;
      start_i      = 1'b1;
      do begin
         tick();
         edges++;
         if (scramble && edges == 5) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~s;
         end
      end while (ready_o !== 1'b1 && edges < DATA_W + 8);
      check({tag, "_ready"}, 64'(ready_o), 64'd1);
      check({tag, "_latency"}, 64'(edges), 64'(lat));
      check({tag, "_result"}, result_o, exp);
      for (int i = 0; i < extra; i++) begin
         tick();
         check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
         check({tag, "_hold_result"}, result_o, exp);
      end
      if (by_annul) annul_i = 1'b1;
      else start_i = 1'b0;
      tick();
      check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_drop_result"}, result_o, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
   endtask

   initial begin
      logic [31:0] edge_vals [5];
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      int          kind;

      edge_vals[0] = 32'h0000_0000;
      edge_vals[1] = 32'h0000_0001;
      edge_vals[2] = 32'h7FFF_FFFF;
      edge_vals[3] = 32'h8000_0000;
      edge_vals[4] = 32'hFFFF_FFFF;

      rst = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      annul_i = 1'b0;
      tick();
      tick();
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      start_i = 1'b0;
      rst = 1'b0;
      tick();
      check("idle_ready", 64'(ready_o), 64'd0);

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 1'b0, 1'b0);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1'b0, 1'b0);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0, 1'b0, 1'b0);
      run_div("div_by0", 1'b1, 32'h1234_5678, 32'd0, 64'd0, 0, 1'b0, 1'b0);
      run_div("divu_by0", 1'b0, 32'hFFFF_FFFF, 32'd0, 64'd0, 2, 1'b0, 1'b0);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, 1'b0, 1'b0);
      run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 0, 1'b0, 1'b0);
      run_div("divu_5_max", 1'b0, 32'd5, 32'hFFFF_FFFF, {32'd5, 32'd0}, 0, 1'b0, 1'b0);
      run_div("divu_hold5", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 5, 1'b0, 1'b0);
      run_div("divu_scramble", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 0, 1'b1, 1'b0);
      run_div("div_annul_done", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1, 1'b0, 1'b1);

      // Annul at iteration 10.
      signed_div_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      repeat (11) tick();
      check("annul10_busy_ready", 64'(ready_o), 64'd0);
      annul_i = 1'b1;
      tick();
      check("annul10_ready", 64'(ready_o), 64'd0);
      check("annul10_result", result_o, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      tick();
      check("annul10_idle_ready", 64'(ready_o), 64'd0);
      run_div("annul10_next", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 1'b0, 1'b0);

      // Annul on the completing edge wins over completion.
      start_i = 1'b1;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      repeat (32) tick();
      check("annul_last_pre_ready", 64'(ready_o), 64'd0);
      annul_i = 1'b1;
      tick();
      check("annul_last_ready", 64'(ready_o), 64'd0);
      check("annul_last_result", result_o, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      tick();

      // Initiator withdrawing start mid-divide.
      start_i = 1'b1;
      repeat (15) tick();
      start_i = 1'b0;
      tick();
      check("withdraw_ready", 64'(ready_o), 64'd0);
      repeat (25) tick();
      check("withdraw_late_ready", 64'(ready_o), 64'd0);

      // Reset at iteration 20 with start held through reset.
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      repeat (21) tick();
      rst = 1'b1;
      tick();
      check("rst20_ready", 64'(ready_o), 64'd0);
      check("rst20_result", result_o, 64'd0);
      rst = 1'b0;
      run_div("rst20_restart", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0, 1'b0, 1'b0);

      for (int n = 0; n < N_RAND; n++) begin
         kind = $urandom_range(0, 5);
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         case (kind)
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'd0;
            3: a = 32'($urandom_range(0, 255));
            4: begin
               a = edge_vals[$urandom_range(0, 4)];
               b = edge_vals[$urandom_range(0, 4)];
            end
            5: b = {{16{b[15]}}, b[15:0]};
            default: ;
         endcase
         run_div("rand", s, a, b, ref_div(s, a, b), (n % 50 == 0) ? 5 : 0,
                 (n % 11 == 3), (n % 7 == 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
